recorre_ram: RTL and testbench
==============================

# recorre_ram

RAM address walker for the Drums Hero sound path. On a qualified button press it sweeps `DireccionRAM` once through the sample region of the current difficulty level, one address per `habilitador` cycle, then parks at that region's base. Its output drives the external sample RAM's address bus; the audio datapath consumes the returned samples.

## Interface
- `BASE_N1`, default 26'h0000000: first address of the level-1 sound region.
- `BASE_N2`, default 26'h0100000: first address of the level-2 sound region.
- `BASE_N3`, default 26'h0200000: first address of the level-3 sound region.
- `LEN_N1`, `LEN_N2`, `LEN_N3`, default 26'h0100000 each: region length in words, must be ≥ 2.
- `habilitador` in 1: sample-rate clock. One clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `enable` in 1: playback permitted, level-sensitive.
- `nivel2` in 1: selects level 2.
- `nivel3` in 1: selects level 3; has priority over `nivel2`.
- `boton` in 1: drum pad, asynchronous, active-high press.
- `DireccionRAM` out 26: current RAM address, registered.

## Operation
- **Level select:** `nivel3=1` selects level 3, else `nivel2=1` selects level 2, else level 1. This is combinational: `sel_base` and `sel_len` follow the selected level.
- **Button path:** `boton` passes through a 2-flop synchronizer, then a rising-edge detector (`s2 & ~s3`). All three flops reset to 0. The result is `start`, a one-cycle pulse.
- **States:** IDLE, PLAY. The latched registers `base_q` and `len_q` capture the level at play start.
- **IDLE:**
  - Each cycle `DireccionRAM` ← `sel_base`, so a level change takes effect the next edge.
  - If `start & enable`: state ← PLAY, `base_q` ← `sel_base`, `len_q` ← `sel_len`, `DireccionRAM` ← `sel_base + 1`.
- **PLAY:**
  - Each edge, `DireccionRAM` ← `DireccionRAM + 1`.
  - When `DireccionRAM == base_q + len_q - 1`, the next edge sets `DireccionRAM` ← `base_q` and state ← IDLE.
- **Level change during PLAY:** ignored until the next play.
- **`enable` low during PLAY:** the next edge sets state ← IDLE and `DireccionRAM` ← `sel_base`. `enable` low overrides everything else.
- **`start` during PLAY (retrigger):** the next edge sets `base_q`/`len_q` ← current level and `DireccionRAM` ← `sel_base + 1`. State stays PLAY. Retrigger has priority over end-of-region.
- **`start` with `enable=0`:** discarded, no pending flag.
- **Arithmetic:** 26-bit unsigned, wraps modulo 2^26. No saturation.

## Timing
- **Reset values:** `DireccionRAM` = 26'h0 (not `BASE_N1`), state IDLE, synchronizer flops 0. After reset is released, IDLE loads `sel_base` on the first edge.
- **Button latency:** if `boton` rises before edge k, `s1`=1 at k and `s2`=1 at k+1, so `start` is high during the cycle k+1→k+2. `DireccionRAM` = base+1 after edge k+2.
- **Sweep:** a full play emits base+1 … base+len−1 on consecutive cycles, then base. Exactly `len_q` edges from start to return to IDLE.
- **Button held:** a held `boton` gives one `start`. A release followed by a new press is required to retrigger.
- **Reset mid-PLAY:** immediately forces `DireccionRAM` = 0 and IDLE. The synchronizer is cleared, so `boton` still high after reset counts as a new rising edge.

## Structure
- **Shared package `recorre_ram_pkg`:**
  - `ADDR_W = 26`
  - state enum `{IDLE, PLAY}`
  - default base/length constants for the three levels
- **Sub-module `sincroniza_boton`:** 2-flop synchronizer plus edge detector. Ports: `habilitador`, `reset`, `boton` → `start`.
- **Top level:** level mux, FSM and address counter.

## Test plan
1. **Reset and idle:** `reset` pulse with `boton=1`, `enable=0`, `nivel2=nivel3=0`, then run 100 cycles → `DireccionRAM` = 0 during reset, 0 after (BASE_N1), and no sweep ever starts.
2. **Level-1 sweep:** `LEN_N1=8`, `enable=1`, `boton` 0→1 before edge k → `DireccionRAM` = 1 at edge k+2, rises to 7 at k+8, returns to 0 at k+9, then stays in IDLE.
3. **Level select in IDLE:** set `nivel2=1` → address becomes 26'h0100000 one edge later. Set `nivel3=1` with `nivel2=1` → 26'h0200000. Clear both → 0.
4. **Level latched in PLAY:** start a level-1 play, set `nivel3=1` mid-sweep → the sweep continues from level-1 addresses to its end, then parks at 26'h0200000.
5. **Abort and retrigger:** drop `enable` at address 4 → next edge gives address 0 and IDLE. Restart, and at address 5 release and re-press `boton` → address 1 two edges after the new press edge.
6. **Asynchronous reset mid-sweep:** assert `reset` between edges at address 3 → `DireccionRAM` = 0 immediately, before the next edge. Release with `boton` held high → a new sweep starts 2 edges later.

Source files
------------

// File: rtl/recorre_ram_pkg.sv
// Shared definitions for the recorre_ram sample-address walker:
// address width, FSM state type and default sound-region layout.
package recorre_ram_pkg;

  localparam int ADDR_W = 26;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PLAY = 1'b1
  } estado_t;

  localparam logic [ADDR_W-1:0] BASE_N1_DEF = 26'h0000000;
  localparam logic [ADDR_W-1:0] BASE_N2_DEF = 26'h0100000;
  localparam logic [ADDR_W-1:0] BASE_N3_DEF = 26'h0200000;
  localparam logic [ADDR_W-1:0] LEN_DEF     = 26'h0100000;

endpackage

// File: rtl/sincroniza_boton.sv
// Drum-pad input conditioning: two-flop synchronizer followed by a
// rising-edge detector that yields a single-cycle start pulse.
module sincroniza_boton
  import recorre_ram_pkg::*;
(
  input  logic habilitador,
  input  logic reset,
  input  logic boton,
  output logic start
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  // Synchronizer chain plus the delayed copy used for edge detection
  always_ff @(posedge habilitador or posedge reset) begin
    if (reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= boton;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // The pulse must land in the same cycle the synchronized level rises
  assign start = r_s2 & ~r_s3;

endmodule

// File: rtl/recorre_ram.sv
// RAM address walker: on a qualified pad press, sweeps the sample region of
// the current difficulty level once, one address per habilitador cycle.
module recorre_ram
  import recorre_ram_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_N1 = BASE_N1_DEF,
  parameter logic [ADDR_W-1:0] BASE_N2 = BASE_N2_DEF,
  parameter logic [ADDR_W-1:0] BASE_N3 = BASE_N3_DEF,
  parameter logic [ADDR_W-1:0] LEN_N1  = LEN_DEF,
  parameter logic [ADDR_W-1:0] LEN_N2  = LEN_DEF,
  parameter logic [ADDR_W-1:0] LEN_N3  = LEN_DEF
) (
  input  logic              habilitador,
  input  logic              reset,
  input  logic              enable,
  input  logic              nivel2,
  input  logic              nivel3,
  input  logic              boton,
  output logic [ADDR_W-1:0] DireccionRAM
);

  logic              w_start;
  logic [ADDR_W-1:0] w_sel_base;
  logic [ADDR_W-1:0] w_sel_len;
  logic              w_fin;

  estado_t           r_estado;
  logic [ADDR_W-1:0] r_direccion;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_len;

  sincroniza_boton u_sincroniza_boton (
    .habilitador (habilitador),
    .reset       (reset),
    .boton       (boton),
    .start       (w_start)
  );

  // Level select: level 3 outranks level 2, level 1 is the fallback
  always_comb begin
    w_sel_base = BASE_N1;
    w_sel_len  = LEN_N1;
    if (nivel3) begin
      w_sel_base = BASE_N3;
      w_sel_len  = LEN_N3;
    end else if (nivel2) begin
      w_sel_base = BASE_N2;
      w_sel_len  = LEN_N2;
    end else begin
      w_sel_base = BASE_N1;
      w_sel_len  = LEN_N1;
    end
  end

  // Last word of the region latched at play start (modulo 2^26)
  assign w_fin = (r_direccion == (r_base + r_len - 26'd1));

  // Playback FSM and address counter; priority in PLAY is abort, retrigger, end
  always_ff @(posedge habilitador or posedge reset) begin
    if (reset) begin
      r_estado    <= IDLE;
      r_direccion <= 26'h0000000;
      r_base      <= 26'h0000000;
      r_len       <= 26'h0000000;
    end else begin
      case (r_estado)
        IDLE: begin
          if (w_start && enable) begin
            r_estado    <= PLAY;
            r_base      <= w_sel_base;
            r_len       <= w_sel_len;
            r_direccion <= w_sel_base + 26'd1;
          end else begin
            r_direccion <= w_sel_base;
          end
        end
        PLAY: begin
          if (!enable) begin
            r_estado    <= IDLE;
            r_direccion <= w_sel_base;
          end else if (w_start) begin
            r_base      <= w_sel_base;
            r_len       <= w_sel_len;
            r_direccion <= w_sel_base + 26'd1;
          end else if (w_fin) begin
            r_estado    <= IDLE;
            r_direccion <= r_base;
          end else begin
            r_direccion <= r_direccion + 26'd1;
          end
        end
        default: begin
          r_estado    <= IDLE;
          r_direccion <= w_sel_base;
        end
      endcase
    end
  end

  assign DireccionRAM = r_direccion;

endmodule

// File: tb/tb_recorre_ram.sv
// Self-checking bench for recorre_ram: a reference model pushes the expected
// address per edge into a queue; scenario tasks pop it and add fixed checks.
module tb_recorre_ram;

  localparam logic [25:0] B1 = 26'h0000000;
  localparam logic [25:0] B2 = 26'h0100000;
  localparam logic [25:0] B3 = 26'h0200000;
  localparam logic [25:0] L1 = 26'd8;
  localparam logic [25:0] L2 = 26'd16;
  localparam logic [25:0] L3 = 26'd5;

  logic        habilitador = 1'b0;
  logic        reset       = 1'b1;
  logic        enable      = 1'b0;
  logic        nivel2      = 1'b0;
  logic        nivel3      = 1'b0;
  logic        boton       = 1'b0;
  logic [25:0] DireccionRAM;

  int n_checks = 0;
  int n_errors = 0;

  logic [25:0] sb[$];

  typedef struct packed {
    logic        s1;
    logic        s2;
    logic        s3;
    logic        play;
    logic [25:0] addr;
    logic [25:0] base;
    logic [25:0] rem;
  } mstate_t;

  mstate_t m = '0;
  mstate_t m_nxt;

  recorre_ram #(
    .BASE_N1 (B1), .BASE_N2 (B2), .BASE_N3 (B3),
    .LEN_N1  (L1), .LEN_N2  (L2), .LEN_N3  (L3)
  ) dut (
    .habilitador  (habilitador),
    .reset        (reset),
    .enable       (enable),
    .nivel2       (nivel2),
    .nivel3       (nivel3),
    .boton        (boton),
    .DireccionRAM (DireccionRAM)
  );

  always #5 habilitador = ~habilitador;

  // Reference model: counts remaining words instead of comparing addresses
  function automatic mstate_t model_step(mstate_t c, logic b, logic en, logic n2, logic n3);
    mstate_t     n;
    logic        st;
    logic [25:0] sbase;
    logic [25:0] slen;
    n     = c;
    st    = c.s2 & ~c.s3;
    n.s1  = b;
    n.s2  = c.s1;
    n.s3  = c.s2;
    sbase = n3 ? B3 : (n2 ? B2 : B1);
    slen  = n3 ? L3 : (n2 ? L2 : L1);
    if (!c.play) begin
      if (st && en) begin
        n.play = 1'b1; n.base = sbase; n.rem = slen - 26'd2; n.addr = sbase + 26'd1;
      end else begin
        n.addr = sbase;
      end
    end else if (!en) begin
      n.play = 1'b0; n.addr = sbase;
    end else if (st) begin
      n.base = sbase; n.rem = slen - 26'd2; n.addr = sbase + 26'd1;
    end else if (c.rem == 26'd0) begin
      n.play = 1'b0; n.addr = c.base;
    end else begin
      n.addr = c.addr + 26'd1; n.rem = c.rem - 26'd1;
    end
    return n;
  endfunction

  assign m_nxt = model_step(m, boton, enable, nivel2, nivel3);

  always @(posedge habilitador or posedge reset) begin
    if (reset) begin
      m <= '0;
      sb.delete();
    end else begin
      m <= m_nxt;
      sb.push_back(m_nxt.addr);
    end
  end

  task automatic test_reset();
    logic [25:0] e;
    boton = 1'b1; enable = 1'b0; nivel2 = 1'b0; nivel3 = 1'b0; reset = 1'b1;
    @(negedge habilitador);
    n_checks++;
    if (DireccionRAM !== 26'h0) begin
      n_errors++; $display("FAIL reset_hold got %h want %h", DireccionRAM, 26'h0);
    end
    reset = 1'b0;
    for (int j = 0; j < 100; j++) begin
      @(negedge habilitador);
      if (sb.size() != 0) e = sb.pop_front(); else e = 'x;
      n_checks++;
      if (DireccionRAM !== e) begin
        n_errors++; $display("FAIL reset_sb j=%0d got %h want %h", j, DireccionRAM, e);
      end
      n_checks++;
      if (DireccionRAM !== B1) begin
        n_errors++; $display("FAIL reset_idle j=%0d got %h want %h", j, DireccionRAM, B1);
      end
    end
  endtask

  task automatic test_sweep();
    logic [25:0] e;
    logic [25:0] r;
    enable = 1'b1;
    for (int j = -4; j < 12; j++) begin
      boton = (j >= 0);
      @(negedge habilitador);
      if (sb.size() != 0) e = sb.pop_front(); else e = 'x;
      n_checks++;
      if (DireccionRAM !== e) begin
        n_errors++; $display("FAIL sweep_sb j=%0d got %h want %h", j, DireccionRAM, e);
      end
      r = (j >= 2 && j <= 8) ? 26'(j - 1) : 26'd0;
      n_checks++;
      if (DireccionRAM !== r) begin
        n_errors++; $display("FAIL sweep_addr j=%0d got %h want %h", j, DireccionRAM, r);
      end
    end
    boton = 1'b0;
  endtask

  task automatic test_levels();
    logic [25:0] e;
    logic [25:0] r;
    for (int j = 0; j < 5; j++) begin
      case (j)
        0:       begin nivel2 = 1'b1; nivel3 = 1'b0; r = B2; end
        1:       begin nivel2 = 1'b1; nivel3 = 1'b1; r = B3; end
        2:       begin nivel2 = 1'b0; nivel3 = 1'b0; r = B1; end
        3:       begin nivel2 = 1'b0; nivel3 = 1'b1; r = B3; end
        default: begin nivel2 = 1'b0; nivel3 = 1'b0; r = B1; end
      endcase
      @(negedge habilitador);
      if (sb.size() != 0) e = sb.pop_front(); else e = 'x;
      n_checks++;
      if (DireccionRAM !== e) begin
        n_errors++; $display("FAIL levels_sb j=%0d got %h want %h", j, DireccionRAM, e);
      end
      n_checks++;
      if (DireccionRAM !== r) begin
        n_errors++; $display("FAIL levels_addr j=%0d got %h want %h", j, DireccionRAM, r);
      end
    end
  endtask

  task automatic test_latch();
    logic [25:0] e;
    logic [25:0] r;
    for (int j = -4; j < 12; j++) begin
      boton  = (j >= 0);
      nivel3 = (j >= 4);
      @(negedge habilitador);
      if (sb.size() != 0) e = sb.pop_front(); else e = 'x;
      n_checks++;
      if (DireccionRAM !== e) begin
        n_errors++; $display("FAIL latch_sb j=%0d got %h want %h", j, DireccionRAM, e);
      end
      if (j >= 2) begin
        r = (j <= 8) ? 26'(j - 1) : ((j == 9) ? B1 : B3);
        n_checks++;
        if (DireccionRAM !== r) begin
          n_errors++; $display("FAIL latch_addr j=%0d got %h want %h", j, DireccionRAM, r);
        end
      end
    end
    boton = 1'b0; nivel3 = 1'b0;
  endtask

  task automatic test_abort_retrigger();
    logic [25:0] e;
    logic [25:0] r;
    for (int j = -4; j < 10; j++) begin
      boton  = (j >= 0);
      enable = (j != 6);
      @(negedge habilitador);
      if (sb.size() != 0) e = sb.pop_front(); else e = 'x;
      n_checks++;
      if (DireccionRAM !== e) begin
        n_errors++; $display("FAIL abort_sb j=%0d got %h want %h", j, DireccionRAM, e);
      end
      r = (j >= 2 && j <= 5) ? 26'(j - 1) : 26'd0;
      n_checks++;
      if (DireccionRAM !== r) begin
        n_errors++; $display("FAIL abort_addr j=%0d got %h want %h", j, DireccionRAM, r);
      end
    end
    enable = 1'b1; nivel2 = 1'b1;
    for (int j = -4; j < 27; j++) begin
      boton = (j >= 0 && j != 7);
      @(negedge habilitador);
      if (sb.size() != 0) e = sb.pop_front(); else e = 'x;
      n_checks++;
      if (DireccionRAM !== e) begin
        n_errors++; $display("FAIL retrig_sb j=%0d got %h want %h", j, DireccionRAM, e);
      end
      if (j < 2 || j >= 25)  r = B2;
      else if (j <= 9)       r = B2 + 26'(j - 1);
      else                   r = B2 + 26'(j - 9);
      n_checks++;
      if (DireccionRAM !== r) begin
        n_errors++; $display("FAIL retrig_addr j=%0d got %h want %h", j, DireccionRAM, r);
      end
    end
    boton = 1'b0; nivel2 = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [25:0] e;
    logic [25:0] r;
    for (int j = -4; j < 5; j++) begin
      boton = (j >= 0);
      @(negedge habilitador);
      if (sb.size() != 0) e = sb.pop_front(); else e = 'x;
      n_checks++;
      if (DireccionRAM !== e) begin
        n_errors++; $display("FAIL arst_pre_sb j=%0d got %h want %h", j, DireccionRAM, e);
      end
    end
    n_checks++;
    if (DireccionRAM !== 26'd3) begin
      n_errors++; $display("FAIL arst_before got %h want %h", DireccionRAM, 26'd3);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (DireccionRAM !== 26'h0) begin
      n_errors++; $display("FAIL arst_immediate got %h want %h", DireccionRAM, 26'h0);
    end
    @(negedge habilitador);
    reset = 1'b0;
    for (int j = 1; j < 13; j++) begin
      @(negedge habilitador);
      if (sb.size() != 0) e = sb.pop_front(); else e = 'x;
      n_checks++;
      if (DireccionRAM !== e) begin
        n_errors++; $display("FAIL arst_post_sb j=%0d got %h want %h", j, DireccionRAM, e);
      end
      r = (j >= 3 && j <= 9) ? 26'(j - 2) : 26'd0;
      n_checks++;
      if (DireccionRAM !== r) begin
        n_errors++; $display("FAIL arst_post_addr j=%0d got %h want %h", j, DireccionRAM, r);
      end
    end
    boton = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_levels();
    test_latch();
    test_abort_retrigger();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
